// File: rtl/iob_clint_bus_arb.sv
// ---------------------------------------------------------------------------
// iob_clint_bus_arb
//
// Round-robin arbiter that shares the single IOb slave port of iob_clint
// between N_MASTERS IOb requesters (per-core CSR paths, debug module, ...).
// Only one transaction is in flight at a time. Read data is routed back only
// to the master that issued the read. Priority rotates to the master after
// the owner once a transaction completes (write accepted or read returned).
//
// Ports
//   clk_i, arst_i, cke_i   clock, async active-high reset, clock enable
//   m_avalid_i             per-master request valid
//   m_addr_i               packed addresses, master k at [k*ADDR_W +: ADDR_W]
//   m_wdata_i              packed write data, master k at [k*DATA_W +: DATA_W]
//   m_wstrb_i              packed byte strobes, all-zero strobe means a read
//   m_ready_o              per-master request accepted
//   m_rvalid_o             per-master read data valid (only the owner)
//   m_rdata_o              read data broadcast, qualified by m_rvalid_o
//   s_avalid_o ... s_wstrb_o  request towards the CLINT
//   s_ready_i, s_rvalid_i, s_rdata_i  CLINT handshake and read data
//   grant_o                one-hot current owner, zero when idle
//   busy_o                 arbiter is holding a transaction
//
// The s_* request fields and the m_ready/m_rvalid/m_rdata returns are
// combinational from the held owner so that a write completes in two cycles
// and read data reaches the master in the cycle the CLINT returns it.
// ---------------------------------------------------------------------------
module iob_clint_bus_arb #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    input  logic                            cke_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            busy_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    owner_r;
    logic [IDX_W-1:0]    owner_nxt_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    ptr_nxt_s;

    logic [N_MASTERS-1:0] owner_onehot_s;
    logic                 own_avalid_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_wdata_s;
    logic [STRB_W-1:0]    sel_wstrb_s;

    logic [N_MASTERS-1:0] ge_ptr_mask_s;
    logic [N_MASTERS-1:0] req_hi_s;
    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;

    // Index of the master after idx. N_MASTERS need not be a power of two,
    // so the wrap from the last master back to 0 is explicit.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == LAST_IDX) begin
            res = '0;
        end else begin
            res = idx + IDX_W'(1'b1);
        end
        return res;
    endfunction

    // Lowest set bit position of vec; 0 when vec is empty (caller qualifies).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MASTERS-1:0] vec);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            res = vec[k] ? IDX_W'(k) : res;
        end
        return res;
    endfunction

    // Owner decode and AND-OR mux of the owner's request fields.
    always_comb begin
        owner_onehot_s = '0;
        sel_addr_s     = '0;
        sel_wdata_s    = '0;
        sel_wstrb_s    = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            owner_onehot_s[k] = (owner_r == IDX_W'(k));
        end
        for (int k = 0; k < N_MASTERS; k++) begin
            sel_addr_s  = sel_addr_s  | (m_addr_i[k*ADDR_W +: ADDR_W]  & {ADDR_W{owner_onehot_s[k]}});
            sel_wdata_s = sel_wdata_s | (m_wdata_i[k*DATA_W +: DATA_W] & {DATA_W{owner_onehot_s[k]}});
            sel_wstrb_s = sel_wstrb_s | (m_wstrb_i[k*STRB_W +: STRB_W] & {STRB_W{owner_onehot_s[k]}});
        end
        own_avalid_s = |(m_avalid_i & owner_onehot_s);
    end

    // Round-robin pick: first requester at or above ptr, otherwise the first
    // requester below ptr (the wrapped part of the scan).
    always_comb begin
        ge_ptr_mask_s = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            ge_ptr_mask_s[k] = (IDX_W'(k) >= ptr_r);
        end
        req_hi_s     = m_avalid_i & ge_ptr_mask_s;
        pick_found_s = |m_avalid_i;
        pick_idx_s   = (|req_hi_s) ? lowest_idx(req_hi_s) : lowest_idx(m_avalid_i);
    end

    // Next-state, owner/pointer update and all bus-facing outputs.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        s_avalid_o  = 1'b0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        m_ready_o   = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        grant_o     = '0;
        busy_o      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_GRANT;
                    owner_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_GRANT: begin
                busy_o     = 1'b1;
                grant_o    = owner_onehot_s;
                s_avalid_o = own_avalid_s;
                s_addr_o   = sel_addr_s;
                s_wdata_o  = sel_wdata_s;
                s_wstrb_o  = sel_wstrb_s;
                m_ready_o  = s_ready_i ? owner_onehot_s : '0;
                if (!own_avalid_s) begin
                    // Owner withdrew before acceptance: abandon without
                    // rotating so the same master is not penalised.
                    state_nxt_s = ST_IDLE;
                end else if (s_ready_i) begin
                    if (sel_wstrb_s != '0) begin
                        state_nxt_s = ST_IDLE;
                        ptr_nxt_s   = next_idx(owner_r);
                    end else begin
                        state_nxt_s = ST_WAIT_RD;
                    end
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end

            ST_WAIT_RD: begin
                busy_o  = 1'b1;
                grant_o = owner_onehot_s;
                if (s_rvalid_i) begin
                    m_rvalid_o  = owner_onehot_s;
                    m_rdata_o   = s_rdata_i;
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = next_idx(owner_r);
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                end
            end

            default: begin
                // Unused encoding: outputs stay quiet and the FSM recovers.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, owner and priority registers; cke_i low freezes all of them.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
        end else if (cke_i) begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end else begin
            state_r <= state_r;
            owner_r <= owner_r;
            ptr_r   <= ptr_r;
        end
    end

endmodule

// File: tb/tb_iob_clint_bus_arb.sv
// ---------------------------------------------------------------------------
// Testbench for iob_clint_bus_arb with three masters (non-power-of-two wrap).
// A transaction-level model tracks "who holds the bus" and "is a read
// outstanding" and predicts every output each cycle; directed scenarios add
// literal expectations on grant order, read routing and cycle timing.
// Inputs change on the falling edge; outputs are sampled after it.
// ---------------------------------------------------------------------------
module tb_iob_clint_bus_arb;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              arst_i;
    logic              cke_i;
    logic [N-1:0]      m_avalid_i;
    logic [N*AW-1:0]   m_addr_i;
    logic [N*DW-1:0]   m_wdata_i;
    logic [N*SW-1:0]   m_wstrb_i;
    logic [N-1:0]      m_ready_o;
    logic [N-1:0]      m_rvalid_o;
    logic [DW-1:0]     m_rdata_o;
    logic              s_avalid_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [SW-1:0]     s_wstrb_o;
    logic              s_ready_i;
    logic              s_rvalid_i;
    logic [DW-1:0]     s_rdata_i;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    logic          av_arr    [N];
    logic [AW-1:0] addr_arr  [N];
    logic [DW-1:0] wdata_arr [N];
    logic [SW-1:0] wstrb_arr [N];

    iob_clint_bus_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .arst_i(arst_i), .cke_i(cke_i),
        .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_wstrb_i(m_wstrb_i), .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .grant_o(grant_o),
        .busy_o(busy_o)
    );

    // Pack per-master request fields onto the bus vectors.
    always_comb begin
        m_avalid_i = '0;
        m_addr_i   = '0;
        m_wdata_i  = '0;
        m_wstrb_i  = '0;
        for (int k = 0; k < N; k++) begin
            m_avalid_i[k]          = av_arr[k];
            m_addr_i[k*AW +: AW]   = addr_arr[k];
            m_wdata_i[k*DW +: DW]  = wdata_arr[k];
            m_wstrb_i[k*SW +: SW]  = wstrb_arr[k];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

    // Event logs filled by the compare process.
    int                gnt_log [$];
    logic [N+DW-1:0]   rv_log  [$];

    function automatic int gnt_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    function automatic logic [N+DW-1:0] rv_at(input int i);
        return (i < rv_log.size()) ? rv_log[i] : '1;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit mdl_busy  = 1'b0;
    bit mdl_rd    = 1'b0;
    int mdl_owner = 0;
    int mdl_ptr   = 0;

    initial begin : compare
        logic [N-1:0]  e_grant, e_mready, e_mrv;
        logic          e_busy, e_sav;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        logic [SW-1:0] e_wstrb;
        int            k;
        forever begin
            @(negedge clk);
            #3;
            if (arst_i) begin
                mdl_busy = 1'b0; mdl_rd = 1'b0; mdl_owner = 0; mdl_ptr = 0;
            end
            e_grant = '0; e_mready = '0; e_mrv = '0; e_busy = 1'b0; e_sav = 1'b0;
            e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rdata = '0;
            if (mdl_busy) begin
                e_busy = 1'b1;
                e_grant[mdl_owner] = 1'b1;
                if (!mdl_rd) begin
                    e_sav   = av_arr[mdl_owner];
                    e_addr  = addr_arr[mdl_owner];
                    e_wdata = wdata_arr[mdl_owner];
                    e_wstrb = wstrb_arr[mdl_owner];
                    e_mready[mdl_owner] = s_ready_i;
                end else if (s_rvalid_i) begin
                    e_mrv[mdl_owner] = 1'b1;
                    e_rdata = s_rdata_i;
                end
            end
            chk("cyc_grant",  grant_o,    e_grant);
            chk("cyc_busy",   busy_o,     e_busy);
            chk("cyc_savalid", s_avalid_o, e_sav);
            chk("cyc_mready", m_ready_o,  e_mready);
            chk("cyc_mrvalid", m_rvalid_o, e_mrv);
            chk("cyc_mrdata", m_rdata_o,  e_rdata);
            if (!mdl_rd) begin
                chk("cyc_saddr",  s_addr_o,  e_addr);
                chk("cyc_swdata", s_wdata_o, e_wdata);
                chk("cyc_swstrb", s_wstrb_o, e_wstrb);
            end
            if (s_avalid_o && s_ready_i && cke_i && !arst_i) gnt_log.push_back(oh_idx(grant_o));
            if (m_rvalid_o != '0) rv_log.push_back({m_rvalid_o, m_rdata_o});

            // Advance the model to the state after the coming rising edge.
            if (!arst_i && cke_i) begin
                if (!mdl_busy) begin
                    for (int i = 0; i < N; i++) begin
                        k = (mdl_ptr + i) % N;
                        if (av_arr[k]) begin
                            mdl_busy = 1'b1; mdl_rd = 1'b0; mdl_owner = k;
                            break;
                        end
                    end
                end else if (!mdl_rd) begin
                    if (!av_arr[mdl_owner]) begin
                        mdl_busy = 1'b0;
                    end else if (s_ready_i) begin
                        if (wstrb_arr[mdl_owner] != '0) begin
                            mdl_busy = 1'b0;
                            mdl_ptr  = (mdl_owner + 1) % N;
                        end else begin
                            mdl_rd = 1'b1;
                        end
                    end
                end else if (s_rvalid_i) begin
                    mdl_busy = 1'b0; mdl_rd = 1'b0;
                    mdl_ptr  = (mdl_owner + 1) % N;
                end
            end
        end
    end

    // ---------------- CLINT read responder ----------------
    bit            manual_rv = 1'b0;
    int            rd_lat    = 1;
    int            rd_wait   = 0;
    logic [DW-1:0] rd_data_q [$];

    initial begin : responder
        forever begin
            @(negedge clk);
            if (!manual_rv) begin
                s_rvalid_i = 1'b0;
                s_rdata_i  = '0;
                if (rd_wait > 0) begin
                    rd_wait--;
                    if (rd_wait == 0) begin
                        s_rvalid_i = 1'b1;
                        s_rdata_i  = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : '0;
                    end
                end
                #1;
                if (!arst_i && cke_i && s_avalid_o && s_ready_i && s_wstrb_o == '0) rd_wait = rd_lat;
            end
        end
    end

    // One master transaction: raise request, wait for ready, drop after it.
    task automatic do_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
        bit got;
        got = 1'b0;
        @(negedge clk);
        addr_arr[k] = a; wdata_arr[k] = d; wstrb_arr[k] = s; av_arr[k] = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (m_ready_o[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("req_timeout", 64'd0, 64'd1);
        @(negedge clk);
        av_arr[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_i = 1'b1;
        repeat (2) @(negedge clk);
        arst_i = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int fair_q [$];
    int fair_exp [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int n_stable, n_r1, n_r0;

    initial begin : stim
        for (int k = 0; k < N; k++) begin
            av_arr[k] = 1'b0; addr_arr[k] = '0; wdata_arr[k] = '0; wstrb_arr[k] = '0;
        end
        arst_i = 1'b1; cke_i = 1'b1; s_ready_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 64'd0);
        chk("rst_grant", grant_o, 64'd0);
        chk("rst_savalid", s_avalid_o, 64'd0);
        @(negedge clk);
        arst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Single write by master 0, timing pinned cycle by cycle.
        addr_arr[0] = 16'h4000; wdata_arr[0] = 32'h0000_00FF; wstrb_arr[0] = 4'hF; av_arr[0] = 1'b1;
        #1 chk("w1_c0_busy", busy_o, 64'd0);
        @(negedge clk); #1;
        chk("w1_c1_busy", busy_o, 64'd1);
        chk("w1_c1_grant", grant_o, 64'h1);
        chk("w1_c1_savalid", s_avalid_o, 64'd1);
        chk("w1_c1_addr", s_addr_o, 64'h4000);
        chk("w1_c1_wdata", s_wdata_o, 64'hFF);
        chk("w1_c1_wstrb", s_wstrb_o, 64'hF);
        chk("w1_c1_mready", m_ready_o, 64'h1);
        @(negedge clk);
        av_arr[0] = 1'b0;
        #1 chk("w1_c2_busy", busy_o, 64'd0);

        // ptr is now 1: masters 0 and 2 contend, 2 must win, then 0 (wrap).
        gnt_log.delete();
        fork
            do_req(0, 16'h4004, 32'h1111_0000, 4'hF);
            do_req(2, 16'h4008, 32'h2222_0000, 4'hF);
        join
        repeat (2) @(negedge clk);
        chk("wrap_count", gnt_log.size(), 64'd2);
        chk("wrap_first", gnt_at(0), 64'd2);
        chk("wrap_second", gnt_at(1), 64'd0);

        // Reset during WAIT_RD; a late rvalid must be ignored; ptr back to 0.
        manual_rv = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
        rv_log.delete();
        do_req(0, 16'hBFF8, 32'h0, 4'h0);
        chk("rdrst_busy_pre", busy_o, 64'd1);
        arst_i = 1'b1;
        #1;
        chk("rdrst_busy", busy_o, 64'd0);
        chk("rdrst_grant", grant_o, 64'd0);
        chk("rdrst_mrvalid", m_rvalid_o, 64'd0);
        repeat (2) @(negedge clk);
        arst_i = 1'b0;
        @(negedge clk);
        s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rdrst_late_rvalid", m_rvalid_o, 64'd0);
        chk("rdrst_late_rdata", m_rdata_o, 64'd0);
        @(negedge clk);
        s_rvalid_i = 1'b0; s_rdata_i = '0;
        chk("rdrst_no_pulse", rv_log.size(), 64'd0);
        gnt_log.delete();
        fork
            do_req(0, 16'h0100, 32'hA0A0_0000, 4'h1);
            do_req(1, 16'h0104, 32'hB0B0_0000, 4'h2);
        join
        repeat (2) @(negedge clk);
        chk("rdrst_ptr_first", gnt_at(0), 64'd0);
        chk("rdrst_ptr_second", gnt_at(1), 64'd1);

        // Contended reads: data routed only to the issuing master.
        manual_rv = 1'b0; rd_lat = 1;
        rd_data_q.delete();
        rd_data_q.push_back(32'h0000_1234);
        rd_data_q.push_back(32'h0000_5678);
        rv_log.delete();
        fork
            do_req(0, 16'hBFF8, 32'h0, 4'h0);
            do_req(1, 16'hBFFC, 32'h0, 4'h0);
        join
        repeat (4) @(negedge clk);
        chk("rd_count", rv_log.size(), 64'd2);
        chk("rd_m0", rv_at(0), {3'b001, 32'h0000_1234});
        chk("rd_m1", rv_at(1), {3'b010, 32'h0000_5678});

        // Owner withdraws before acceptance: back to idle, nothing forwarded.
        @(negedge clk);
        s_ready_i = 1'b0;
        addr_arr[1] = 16'h0200; wdata_arr[1] = 32'h5555_AAAA; wstrb_arr[1] = 4'hF; av_arr[1] = 1'b1;
        @(negedge clk); #1;
        chk("viol_grant", grant_o, 64'h2);
        av_arr[1] = 1'b0;
        @(negedge clk); #1;
        chk("viol_idle", busy_o, 64'd0);

        // Ready stall: request held stable 4 cycles, single ready pulse.
        @(negedge clk);
        addr_arr[1] = 16'h0010; wdata_arr[1] = 32'hCAFE_BABE; wstrb_arr[1] = 4'h3; av_arr[1] = 1'b1;
        n_stable = 0; n_r1 = 0; n_r0 = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) s_ready_i = 1'b1;
            #1;
            if (s_avalid_o && s_addr_o == 16'h0010 && s_wdata_o == 32'hCAFE_BABE && s_wstrb_o == 4'h3)
                n_stable++;
            n_r1 += int'(m_ready_o[1]);
            n_r0 += int'(m_ready_o[0]);
        end
        @(negedge clk);
        av_arr[1] = 1'b0;
        #1;
        n_r1 += int'(m_ready_o[1]);
        n_r0 += int'(m_ready_o[0]);
        chk("stall_stable", n_stable, 64'd4);
        chk("stall_ready1", n_r1, 64'd1);
        chk("stall_ready0", n_r0, 64'd0);

        // Fairness: all three masters request writes continuously.
        do_reset();
        for (int k = 0; k < N; k++) begin
            addr_arr[k] = AW'(16'h1000 + 16'(k)); wdata_arr[k] = DW'(k + 1); wstrb_arr[k] = 4'hF;
            av_arr[k] = 1'b1;
        end
        fair_q.delete();
        for (int t = 0; t < 60 && fair_q.size() < 9; t++) begin
            @(negedge clk); #1;
            if (s_avalid_o && s_ready_i) fair_q.push_back(oh_idx(grant_o));
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) av_arr[k] = 1'b0;
        chk("fair_count", fair_q.size(), 64'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("fair_%0d", i), (i < fair_q.size()) ? fair_q[i] : -1, fair_exp[i]);
        end

        // Clock enable hold in WAIT_RD.
        manual_rv = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
        repeat (2) @(negedge clk);
        do_req(2, 16'h0008, 32'h0, 4'h0);
        cke_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("cke_busy", busy_o, 64'd1);
            chk("cke_grant", grant_o, 64'h4);
            @(negedge clk);
        end
        cke_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'hA5A5_A5A5;
        #1;
        chk("cke_rvalid", m_rvalid_o, 64'h4);
        chk("cke_rdata", m_rdata_o, 64'hA5A5_A5A5);
        @(negedge clk);
        s_rvalid_i = 1'b0; s_rdata_i = '0;
        #1;
        chk("cke_idle_busy", busy_o, 64'd0);
        chk("cke_idle_grant", grant_o, 64'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, want summary before 200000 time units");
        $fatal(1, "simulation time limit");
    end

endmodule
